// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - command, ALU and result signals of the ALU op sequencer
interface alu_op_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int DEPTH  = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_a;
  logic [DATA_W-1:0]        in_b;
  logic [OP_W-1:0]          in_op;
  logic [DATA_W-1:0]        alu_a;
  logic [DATA_W-1:0]        alu_b;
  logic [OP_W-1:0]          alu_op;
  logic [DATA_W-1:0]        alu_result;
  logic                     alu_zero;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_result;
  logic                     out_zero;
  logic [OP_W-1:0]          out_op;
  logic [$clog2(DEPTH):0]   level;
  logic [7:0]               illegal_cnt;

  modport slave (
    input  in_valid, in_a, in_b, in_op, alu_result, alu_zero, out_ready,
    output in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_zero, out_op,
           level, illegal_cnt
  );

  modport master (
    output in_valid, in_a, in_b, in_op, alu_result, alu_zero, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_zero, out_op,
           level, illegal_cnt
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command FIFO feeding an external ALU with a registered result stage
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [DATA_W-1:0] r_mem_a  [DEPTH];
  logic [DATA_W-1:0] r_mem_b  [DEPTH];
  logic [OP_W-1:0]   r_mem_op [DEPTH];

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_result;
  logic              r_out_zero;
  logic [OP_W-1:0]   r_out_op;
  logic [7:0]        r_illegal_cnt;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_issue;
  logic w_illegal;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == FULL_LEVEL);
  // in_ready depends only on registered occupancy, never on this cycle's pop
  assign w_push    = bus.in_valid && !w_full;
  assign w_issue   = !w_empty && (!r_out_valid || bus.out_ready);
  assign w_illegal = (bus.alu_op[OP_W-1:1] != '0);

  assign bus.in_ready    = !w_full;
  assign bus.alu_a       = w_empty ? '0 : r_mem_a[r_rd_ptr];
  assign bus.alu_b       = w_empty ? '0 : r_mem_b[r_rd_ptr];
  assign bus.alu_op      = w_empty ? '0 : r_mem_op[r_rd_ptr];
  assign bus.out_valid   = r_out_valid;
  assign bus.out_result  = r_out_result;
  assign bus.out_zero    = r_out_zero;
  assign bus.out_op      = r_out_op;
  assign bus.level       = r_level;
  assign bus.illegal_cnt = r_illegal_cnt;

  // Storage is left unreset; the pointers and level alone define valid entries
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]  <= bus.in_a;
      r_mem_b[r_wr_ptr]  <= bus.in_b;
      r_mem_op[r_wr_ptr] <= bus.in_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_zero    <= 1'b0;
      r_out_op      <= '0;
      r_illegal_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end

      if (w_issue) begin
        r_rd_ptr     <= r_rd_ptr + AW'(1);
        r_out_valid  <= 1'b1;
        r_out_result <= bus.alu_result;
        r_out_zero   <= bus.alu_zero;
        r_out_op     <= bus.alu_op;
        if (w_illegal && (r_illegal_cnt != 8'hFF)) begin
          r_illegal_cnt <= r_illegal_cnt + 8'd1;
        end
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      case ({w_push, w_issue})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule
